// File: rtl/button_flag_gen.sv
// Two-button front end: synchronise, debounce and turn presses (plus optional hold-to-repeat)
// into one-cycle, mutually exclusive increment/decrement flags.
module button_flag_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000,
  parameter int unsigned BTN_ACTIVE_LOW  = 1
) (
  input  logic       FPGA_CLK,
  input  logic       FPGA_RST_N,
  input  logic       BTN_UP,
  input  logic       BTN_DOWN,
  output logic       flag_light_1,
  output logic       flag_light_2,
  output logic [1:0] btn_held
);

  localparam int unsigned DebW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TmrMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TmrW   = (TmrMax > 2) ? $clog2(TmrMax) : 1;

  localparam logic            RelLvl     = (BTN_ACTIVE_LOW != 0);
  localparam logic [DebW-1:0] DebLast    = DebW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmrW-1:0] DelayLoad  = TmrW'(REPEAT_DELAY - 1);
  localparam logic [TmrW-1:0] PeriodLoad = TmrW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {StIdle, StPressed, StRepeat, StHeld} state_e;

  logic [1:0] pin;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] pressed;
  logic [1:0] deb;
  logic [1:0] req;

  assign pin     = {BTN_DOWN, BTN_UP};
  assign pressed = sync2_q ^ {2{RelLvl}};

  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      sync1_q <= {2{RelLvl}};
      sync2_q <= {2{RelLvl}};
    end else begin
      sync1_q <= pin;
      sync2_q <= sync1_q;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic [DebW-1:0] cnt_q;
    logic            deb_q;
    state_e          state_q;
    logic [TmrW-1:0] tmr_q;
    logic            req_c;

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
      if (!FPGA_RST_N) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (pressed[i] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DebLast) begin
        deb_q <= ~deb_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    // In StIdle a high deb can only mean a fresh rising edge: every fall returns here.
    always_comb begin
      req_c = 1'b0;
      unique case (state_q)
        StIdle:              req_c = deb_q;
        StPressed, StRepeat: req_c = deb_q && (tmr_q == '0);
        StHeld:              req_c = 1'b0;
      endcase
    end

    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
      if (!FPGA_RST_N) begin
        state_q <= StIdle;
        tmr_q   <= '0;
      end else if (state_q != StIdle && !deb_q) begin
        state_q <= StIdle;
        tmr_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (deb_q) begin
              tmr_q   <= DelayLoad;
              state_q <= (REPEAT_EN != 0) ? StPressed : StHeld;
            end
          end
          StPressed, StRepeat: begin
            if (tmr_q == '0) begin
              tmr_q   <= PeriodLoad;
              state_q <= StRepeat;
            end else begin
              tmr_q <= tmr_q - 1'b1;
            end
          end
          StHeld: ;
        endcase
      end
    end

    assign deb[i] = deb_q;
    assign req[i] = req_c;
  end

  // Simultaneous requests cancel so the net step is zero.
  always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
    if (!FPGA_RST_N) begin
      flag_light_1 <= 1'b0;
      flag_light_2 <= 1'b0;
    end else begin
      flag_light_1 <= req[0] & ~req[1];
      flag_light_2 <= req[1] & ~req[0];
    end
  end

  assign btn_held = deb;

endmodule

// File: tb/tb_button_flag_gen.sv
// Scoreboard bench: expected pulse cycles are queued as pins are driven and matched per cycle
// against a repeating instance and a single-shot instance.
module tb_button_flag_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_up, btn_down;
  logic       f1, f2, nf1, nf2;
  logic [1:0] held, nheld;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // index 0/1: repeating DUT up/down, 2/3: single-shot DUT up/down
  int         exp_q[4][$];
  logic [3:0] fl;

  assign fl = {nf2, nf1, f2, f1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  button_flag_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .BTN_ACTIVE_LOW(1)
  ) dut (
    .FPGA_CLK(clk), .FPGA_RST_N(rst_n), .BTN_UP(btn_up), .BTN_DOWN(btn_down),
    .flag_light_1(f1), .flag_light_2(f2), .btn_held(held)
  );

  button_flag_gen #(
    .DEBOUNCE_CYCLES(4), .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .BTN_ACTIVE_LOW(1)
  ) dut_nr (
    .FPGA_CLK(clk), .FPGA_RST_N(rst_n), .BTN_UP(btn_up), .BTN_DOWN(btn_down),
    .flag_light_1(nf1), .flag_light_2(nf2), .btn_held(nheld)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (exp_q[i].size() > 0 && exp_q[i][0] == cyc) begin
        check_eq($sformatf("pulse%0d@%0d", i, cyc), 32'(fl[i]), 1);
        void'(exp_q[i].pop_front());
      end else if (fl[i]) begin
        check_eq($sformatf("spurious%0d@%0d", i, cyc), 32'(fl[i]), 0);
      end
    end
    check_eq("exclusive", 32'((f1 & f2) | (nf1 & nf2)), 0);
  end

  initial begin
    int n, p, m;
    rst_n    = 1'b0;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_f1", 32'(f1), 0);
    check_eq("rst_f2", 32'(f2), 0);
    check_eq("rst_held", 32'(held), 0);
    check_eq("rst_nheld", 32'(nheld), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Press and hold up: press pulse, then repeats every 5 after a 10-cycle delay.
    n = cyc;
    btn_up = 1'b0;
    p = n + 7;
    exp_q[0].push_back(p);
    for (int k = 10; k <= 35; k += 5) exp_q[0].push_back(p + k);
    exp_q[2].push_back(p);
    wait_until(n + 5);
    check_eq("held_pre", 32'(held), 0);
    wait_until(n + 6);
    check_eq("held_up", 32'(held), 1);
    check_eq("nheld_up", 32'(nheld), 1);
    wait_until(p + 31);
    btn_up = 1'b1;
    n = cyc;
    wait_until(n + 5);
    check_eq("held_rel_pre", 32'(held), 1);
    wait_until(n + 6);
    check_eq("held_rel", 32'(held), 0);
    wait_until(p + 55);
    check_eq("q0_drained", exp_q[0].size(), 0);
    check_eq("q2_drained", exp_q[2].size(), 0);

    // Short glitches on down must be filtered out entirely.
    for (int g = 0; g < 5; g++) begin
      btn_down = 1'b0;
      repeat (3) @(negedge clk);
      btn_down = 1'b1;
      repeat (3) @(negedge clk);
      check_eq($sformatf("glitch_held%0d", g), 32'(held), 0);
      check_eq($sformatf("glitch_nheld%0d", g), 32'(nheld), 0);
    end
    repeat (10) @(negedge clk);

    // Both pressed together: aligned requests cancel until down is released.
    n = cyc;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    p = n + 7;
    exp_q[0].push_back(p + 20);
    exp_q[0].push_back(p + 25);
    exp_q[0].push_back(p + 30);
    wait_until(n + 6);
    check_eq("held_both", 32'(held), 3);
    wait_until(p + 11);
    btn_down = 1'b1;
    wait_until(p + 26);
    btn_up = 1'b1;
    wait_until(p + 45);
    check_eq("held_both_rel", 32'(held), 0);

    // Reset mid-repeat while up stays held.
    n = cyc;
    btn_up = 1'b0;
    p = n + 7;
    exp_q[0].push_back(p);
    exp_q[0].push_back(p + 10);
    exp_q[2].push_back(p);
    wait_until(p + 10);
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_f1", 32'(f1), 0);
    check_eq("midrst_held", 32'(held), 0);
    check_eq("midrst_nheld", 32'(nheld), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m = cyc;
    p = m + 7;
    exp_q[0].push_back(p);
    exp_q[0].push_back(p + 10);
    exp_q[0].push_back(p + 15);
    exp_q[2].push_back(p);
    wait_until(m + 6);
    check_eq("held_after_rst", 32'(held), 1);
    wait_until(p + 12);
    btn_up = 1'b1;
    wait_until(p + 40);

    for (int i = 0; i < 4; i++) check_eq($sformatf("final_q%0d", i), exp_q[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
